// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFillReq,
    StFillWait,
    StFillDone
  } state_e;

  localparam int unsigned OffW     = 2;  // log2 of the 4-word line
  localparam int unsigned DefLines = 128;
  localparam int unsigned DefIdxW  = $clog2(DefLines);
  localparam int unsigned DefTagW  = 32 - DefIdxW - OffW - 2;

  localparam logic [31:0] NopInstr = 32'd0;

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned lines);
    return addr_w - $clog2(lines) - OffW - 2;
  endfunction

endpackage

// File: rtl/icache_dpram.sv
// Single-clock RAM: one write port, one registered read port (block-RAM friendly).
module icache_dpram #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 512,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache between the fetch stage and the memory bus.
// Lookup result is resolved in the cycle after the request, from the RAM read registers.
module icache_fetch
  import icache_pkg::*;
#(
  parameter int unsigned LINES      = 128,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_hold,
  input  logic              cpu_clear,
  output logic [31:0]       cpu_q,
  output logic              cpu_ready,
  input  logic              inv_all,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_start,
  input  logic [31:0]       bus_q,
  input  logic              bus_done
);

  localparam int unsigned IdxW  = $clog2(LINES);
  localparam int unsigned TagW  = tag_w(ADDR_W, LINES);
  localparam int unsigned WaW   = ADDR_W - 2;
  localparam int unsigned RamAw = IdxW + OffW;

  state_e            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [OffW-1:0]   cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [WaW-1:0]    miss_q, miss_d;
  logic              lk_q, lk_d;
  logic [WaW-1:0]    lk_addr_q, lk_addr_d;
  logic              lk_vbit_q, lk_vbit_d;
  logic              lk_force_q, lk_force_d;
  logic              hold_q, hold_d;
  logic              clr_q, clr_d;
  logic [31:0]       out_q, out_d;
  logic              rdy_q, rdy_d;

  logic [WaW-1:0]    cpu_wa, rd_wa;
  logic [31:0]       data_rd;
  logic [TagW-1:0]   tag_rd;
  logic              data_we, tag_we, hit, miss;
  logic              unused_addr;

  assign cpu_wa      = cpu_addr[ADDR_W-1:2];
  assign unused_addr = ^cpu_addr[1:0];
  assign bus_start   = (state_q == StFillReq);
  assign bus_addr    = {miss_q[WaW-1:OffW], cnt_q, 2'b00};

  icache_dpram #(
    .Width(32),
    .Depth(LINES * LINE_WORDS)
  ) u_data (
    .clk_i  (clk),
    .we_i   (data_we),
    .waddr_i({miss_q[RamAw-1:OffW], cnt_q}),
    .wdata_i(bus_q),
    .raddr_i(rd_wa[RamAw-1:0]),
    .rdata_o(data_rd)
  );

  icache_dpram #(
    .Width(TagW),
    .Depth(LINES)
  ) u_tag (
    .clk_i  (clk),
    .we_i   (tag_we),
    .waddr_i(miss_q[RamAw-1:OffW]),
    .wdata_i(miss_q[WaW-1:RamAw]),
    .raddr_i(rd_wa[RamAw-1:OffW]),
    .rdata_o(tag_rd)
  );

  // The post-fill lookup forces the tag match: the tag RAM write lands on the same edge.
  always_comb begin
    hit       = lk_vbit_q && (lk_force_q || (tag_rd == lk_addr_q[WaW-1:RamAw]));
    miss      = 1'b0;
    cpu_q     = NopInstr;
    cpu_ready = 1'b0;
    if (state_q == StIdle) begin
      if (hold_q) begin
        cpu_q     = out_q;
        cpu_ready = rdy_q;
      end else if (clr_q) begin
        cpu_ready = 1'b1;
      end else if (lk_q) begin
        if (hit) begin
          cpu_q     = data_rd;
          cpu_ready = 1'b1;
        end else begin
          miss = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    miss_d     = miss_q;
    lk_d       = 1'b0;
    lk_addr_d  = lk_addr_q;
    lk_vbit_d  = 1'b0;
    lk_force_d = 1'b0;
    hold_d     = 1'b0;
    clr_d      = 1'b0;
    out_d      = cpu_q;
    rdy_d      = cpu_ready;
    data_we    = 1'b0;
    tag_we     = 1'b0;
    rd_wa      = cpu_wa;

    unique case (state_q)
      StIdle: begin
        if (miss) begin
          state_d = StFillReq;
          miss_d  = lk_addr_q;
          cnt_d   = '0;
        end else if (cpu_hold) begin
          hold_d = 1'b1;
        end else if (cpu_clear) begin
          clr_d = 1'b1;
        end else begin
          lk_d      = 1'b1;
          lk_addr_d = cpu_wa;
          lk_vbit_d = valid_q[cpu_wa[RamAw-1:OffW]];
        end
        if (inv_all) begin
          valid_d = '0;
        end
      end
      StFillReq: begin
        state_d = StFillWait;
      end
      StFillWait: begin
        if (bus_done) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == OffW'(LINE_WORDS - 1)) ? StFillDone : StFillReq;
        end
      end
      StFillDone: begin
        tag_we = 1'b1;
        if (!pend_q && !inv_all) begin
          valid_d[miss_q[RamAw-1:OffW]] = 1'b1;
        end
        pend_d     = 1'b0;
        state_d    = StIdle;
        rd_wa      = miss_q;
        lk_d       = 1'b1;
        lk_addr_d  = miss_q;
        lk_vbit_d  = !pend_q && !inv_all;
        lk_force_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // An invalidate mid-fill lets the line finish but keeps it invalid.
    if (inv_all && (state_q != StIdle)) begin
      valid_d = '0;
      if (state_q != StFillDone) begin
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      miss_q     <= '0;
      lk_q       <= 1'b0;
      lk_addr_q  <= '0;
      lk_vbit_q  <= 1'b0;
      lk_force_q <= 1'b0;
      hold_q     <= 1'b0;
      clr_q      <= 1'b0;
      out_q      <= NopInstr;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      miss_q     <= miss_d;
      lk_q       <= lk_d;
      lk_addr_q  <= lk_addr_d;
      lk_vbit_q  <= lk_vbit_d;
      lk_force_q <= lk_force_d;
      hold_q     <= hold_d;
      clr_q      <= clr_d;
      out_q      <= out_d;
      rdy_q      <= rdy_d;
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// Scoreboard bench for icache_fetch: stimulus queues expected words/bus addresses,
// monitors pop and compare whenever cpu_ready or bus_start is seen.
module tb_icache_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr;
  logic        cpu_hold, cpu_clear, inv_all;
  logic [31:0] cpu_q, bus_addr, bus_q;
  logic        cpu_ready, bus_start, bus_done;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int sc;
  logic [31:0] exp_q[$];
  logic [31:0] exp_bus[$];

  logic        bus_en = 1'b1;
  logic        stray = 1'b0;
  logic        arm = 1'b0;
  logic [31:0] arm_addr = '0;

  icache_fetch dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_addr (cpu_addr),
    .cpu_hold (cpu_hold),
    .cpu_clear(cpu_clear),
    .cpu_q    (cpu_q),
    .cpu_ready(cpu_ready),
    .inv_all  (inv_all),
    .bus_addr (bus_addr),
    .bus_start(bus_start),
    .bus_q    (bus_q),
    .bus_done (bus_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      32'hC:   return 32'h44;
      default: return a | 32'h1000_0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Memory with a one-cycle latency; acts just after the falling edge.
  initial begin
    bus_done = 1'b0;
    bus_q    = '0;
    forever begin
      @(negedge clk);
      #1;
      if (bus_en) begin
        bus_done = 1'b0;
        if (arm) begin
          bus_done = 1'b1;
          bus_q    = mem_word(arm_addr);
          arm      = 1'b0;
        end
        if (bus_start === 1'b1) begin
          arm      = 1'b1;
          arm_addr = bus_addr;
        end
      end else begin
        bus_done = stray;
        bus_q    = 32'hDEAD_BEEF;
      end
    end
  end

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (cpu_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_ready got=%h exp=none", cpu_q);
        end else begin
          e = exp_q.pop_front();
          check("cpu_q", cpu_q, e);
        end
      end
      if (bus_start === 1'b1) begin
        start_cnt++;
        if (exp_bus.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_bus_start got=%h exp=none", bus_addr);
        end else begin
          e = exp_bus.pop_front();
          check("bus_addr", bus_addr, e);
        end
      end
    end
  end

  task automatic cyc(input logic [31:0] a, input logic [31:0] d);
    cpu_addr = a;
    exp_q.push_back(d);
    @(negedge clk);
  endtask

  task automatic push_fill(input logic [31:0] a);
    for (int i = 0; i < 4; i++) begin
      exp_bus.push_back((a & ~32'hF) + 32'(4 * i));
    end
  endtask

  // kind 1: inv_all pulse in the word-2 FILL_WAIT cycle; kind 2: end the stray bus_done.
  task automatic wait_ready(input int exp_n, input string name, input int kind);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (kind == 1 && n == 7) begin
        check("inv_word2_addr", bus_addr, 32'h28);
        inv_all = 1'b1;
      end
      if (kind == 1 && n == 8) inv_all = 1'b0;
      if (kind == 2 && n == 1) begin
        stray  = 1'b0;
        bus_en = 1'b1;
      end
    end while (cpu_ready !== 1'b1 && n < 100);
    check({name, "_latency"}, 32'(n), 32'(exp_n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    cpu_addr  = '0;
    cpu_hold  = 1'b0;
    cpu_clear = 1'b0;
    inv_all   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, cpu_ready}, 32'd0);
    check("rst_q", cpu_q, 32'd0);
    check("rst_start", {31'd0, bus_start}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);

    // Cold miss: first lookup after release
    push_fill(32'h0);
    exp_q.push_back(32'h11);
    reset = 1'b1;
    wait_ready(11, "cold", 0);

    // Hit stream, no bus traffic
    sc = start_cnt;
    cyc(32'h4, 32'h22);
    cyc(32'h8, 32'h33);
    cyc(32'hC, 32'h44);
    check("hit_no_bus", 32'(start_cnt), 32'(sc));

    // Hold freezes outputs; clear gives a NOP; hold beats clear
    cyc(32'h4, 32'h22);
    cpu_hold = 1'b1;
    repeat (3) cyc(32'h8, 32'h22);
    cpu_hold  = 1'b0;
    cpu_clear = 1'b1;
    cyc(32'h8, 32'h0);
    cpu_clear = 1'b0;
    cyc(32'hC, 32'h44);
    cpu_hold  = 1'b1;
    cpu_clear = 1'b1;
    cyc(32'h0, 32'h44);
    cpu_hold  = 1'b0;
    cpu_clear = 1'b0;

    // Conflict eviction on index 0
    push_fill(32'h800);
    exp_q.push_back(32'h1000_0800);
    cpu_addr = 32'h800;
    wait_ready(11, "evict", 0);
    push_fill(32'h0);
    exp_q.push_back(32'h11);
    cpu_addr = 32'h0;
    wait_ready(11, "refetch0", 0);
    cyc(32'h4, 32'h22);

    // Invalidate mid-fill: line stays invalid and refills once more
    push_fill(32'h20);
    push_fill(32'h20);
    exp_q.push_back(32'h1000_0020);
    cpu_addr = 32'h20;
    wait_ready(21, "inv_fill", 1);
    push_fill(32'h4);
    exp_q.push_back(32'h22);
    cpu_addr = 32'h4;
    wait_ready(11, "inv_cleared_line0", 0);

    // Invalidate in IDLE: same-cycle lookup still hits on the old valid bit
    inv_all = 1'b1;
    cyc(32'h20, 32'h1000_0020);
    inv_all = 1'b0;
    push_fill(32'h24);
    exp_q.push_back(32'h1000_0024);
    cpu_addr = 32'h24;
    wait_ready(11, "inv_idle", 0);

    // Reset during FILL_WAIT, stray bus_done after release
    bus_en = 1'b0;
    exp_bus.push_back(32'h30);
    cpu_addr = 32'h30;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (bus_start !== 1'b1 && n < 20);
      check("midfill_start_seen", {31'd0, bus_start}, 32'd1);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_ready", {31'd0, cpu_ready}, 32'd0);
    check("midrst_q", cpu_q, 32'd0);
    check("midrst_start", {31'd0, bus_start}, 32'd0);
    check("midrst_bus_addr", bus_addr, 32'd0);
    @(negedge clk);
    push_fill(32'h24);
    exp_q.push_back(32'h1000_0024);
    cpu_addr = 32'h24;
    stray    = 1'b1;
    reset    = 1'b1;
    wait_ready(11, "after_reset", 2);

    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("exp_bus_drained", 32'(exp_bus.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
# icache_fetch

Direct-mapped instruction cache between the B32P fetch stage and the shared memory bus. It replaces the fixed-latency instruction memory behind the program counter with a variable-latency source. Hits return a registered instruction word one cycle after request, matching the FE→DE pipeline register. Misses stall the CPU while a 4-word line is refilled from the bus.

## Interface
Parameters:
- `LINES`, 128: number of cache lines; power of two, at least 2.
- `LINE_WORDS`, 4: 32-bit words per line; fixed at 4 for this block.
- `ADDR_W`, 32: CPU byte-address width.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_addr`  in  32  PC, byte address; bits [1:0] ignored.
- `cpu_hold`  in  1  CPU stall_FE; freeze `cpu_q`/`cpu_ready`, ignore `cpu_addr`.
- `cpu_clear`  in  1  CPU flush_FE; next `cpu_q` is 0 (NOP).
- `cpu_q`  out  32  instruction for DE stage (registered).
- `cpu_ready`  out  1  `cpu_q` is valid this cycle; 0 means the CPU must stall FE/DE.
- `inv_all`  in  1  single-cycle pulse; invalidate every line.
- `bus_addr`  out  32  word-aligned refill address.
- `bus_start`  out  1  one-cycle read request pulse.
- `bus_q`  in  32  read data, valid when `bus_done`.
- `bus_done`  in  1  one-cycle completion pulse; at least 1 cycle after `bus_start`.

## Operation
- Address split:
  - offset = addr[3:2]
  - index = addr[3+log2(LINES):4]
  - tag = remaining upper bits
- Storage:
  - data RAM of LINES×4 words
  - tag RAM of LINES entries
  - valid bit-vector held in flops
- States:
  - IDLE
    - Lookup `cpu_addr` each cycle unless `cpu_hold`.
    - On hit: `cpu_q` = word, `cpu_ready` = 1 next cycle.
    - On miss: latch line base address, set word counter to 0, `cpu_ready` = 0, go to FILL_REQ.
  - FILL_REQ: pulse `bus_start` with `bus_addr` = base + 4×counter; go to FILL_WAIT.
  - FILL_WAIT
    - On `bus_done`, write `bus_q` to data RAM at [index][counter] and increment the counter.
    - If counter was 3, go to FILL_DONE; else go to FILL_REQ.
  - FILL_DONE
    - Write tag; set valid unless an invalidate is pending.
    - Clear the pending flag.
    - Go to IDLE, which re-looks-up the held PC.
- `cpu_ready` stays 0 throughout FILL_REQ, FILL_WAIT and FILL_DONE.
- `cpu_hold` takes priority over lookup: outputs hold and no new lookup occurs. A hold does not pause a fill in progress.
- `cpu_clear` in IDLE: next `cpu_q` = 0 and `cpu_ready` = 1. During a fill it has no effect on the fill; the CPU redirects the PC after the fill.
- `inv_all`:
  - In IDLE: clears all valid bits on the next edge. A lookup in the same cycle uses the old valid bits.
  - During a fill: clears all valid bits and sets pending, so the in-flight line completes but stays invalid.
- Reset (async assert, any state):
  - state IDLE, all valid bits 0, counter 0, pending 0
  - `cpu_q` = 0, `cpu_ready` = 0, `bus_start` = 0, `bus_addr` = 0
  - An in-flight bus read is abandoned; a later `bus_done` in IDLE is ignored.
- The first cycle after reset deassert performs a lookup, which always misses.

## Timing
- Hit latency: 1 cycle from `cpu_addr` to registered `cpu_q`. A sustained hit stream gives 1 instruction per cycle.
- Miss penalty, with bus latency L (cycles from `bus_start` to `bus_done`):
  - lookup 1 + 4×(1+L) + FILL_DONE 1 + re-lookup 1
  - L=1 gives 11 cycles from the miss address to `cpu_ready`.
- Exactly one outstanding bus request at a time. `bus_addr` is stable from `bus_start` through `bus_done`.
- Simultaneous `cpu_clear` and `cpu_hold`: hold wins.

## Structure
- Package `icache_pkg`:
  - state enum (IDLE, FILL_REQ, FILL_WAIT, FILL_DONE)
  - localparams for offset/index/tag widths derived from `LINES`
  - NOP constant 32'd0
- Sub-module `icache_dpram`: single-clock RAM with one write port and one registered read port. Instantiate once for data and once for tags so both map to block RAM.
- Valid bits stay in flops so async reset and single-cycle `inv_all` work.

## Test plan
- Cold miss: reset, then PC=0x0, bus L=1 returning 0x11,0x22,0x33,0x44 → four `bus_start` pulses at addrs 0x0,0x4,0x8,0xC; `cpu_ready`=1 with `cpu_q`=0x11 exactly 11 cycles after the request.
- Hit stream: after the fill, PC 0x4,0x8,0xC on consecutive cycles → `cpu_q` 0x22,0x33,0x44 with `cpu_ready`=1 each cycle and no `bus_start`.
- Conflict eviction: LINES=128, fill 0x000, then access 0x800 (same index) → refill occurs; a re-access of 0x000 misses again.
- Hold/clear: `cpu_hold`=1 for 3 cycles during hits → `cpu_q` constant; `cpu_clear` pulse → next `cpu_q`=0, `cpu_ready`=1.
- Invalidate during fill: `inv_all` in FILL_WAIT at word 2 → fill completes, line stays invalid, and the re-lookup issues a new 4-word refill.
- Reset mid-fill: assert `reset`=0 in FILL_WAIT → outputs go to 0 immediately; a stray `bus_done` after release is ignored; the next access misses.
